if_fetch_queue: RTL and testbench



---
 rtl/if_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a decoupling fetch queue.
// Issues sequential word fetches to the synchronous BIOS/IMEM ports and steers
// each returned word by its PC region. The word and its PC go into a DEPTH-entry
// FIFO read by decode through inst_valid/inst_ready. A redirect flushes
// everything queued or in flight and restarts fetch at the new PC.
module if_fetch_queue #(
  parameter int           XLEN        = 32,
  parameter logic [31:0]  RESET_PC    = 32'h0000_0000,
  parameter int           DEPTH       = 4,
  parameter int           IMEM_AW     = 14,
  parameter int           BIOS_AW     = 12,
  parameter logic [3:0]   IMEM_REGION = 4'b0001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [31:0]                imem_dout,
  output logic [BIOS_AW-1:0]         bios_addr,
  input  logic [31:0]                bios_dout,
  output logic [XLEN-1:0]            fetch_pc,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [XLEN-1:0]            inst_pc,
  input  logic                       inst_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Fetch-address generator and single in-flight request.
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_sel_q, req_sel_d;

  // FIFO bookkeeping.
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // FIFO storage; no reset needed since count gates visibility.
  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     credits_used;
  logic [31:0]     push_word;
  logic            unused_redirect_lsbs;

  // Word alignment drops the low two bits of the redirect target.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid & inst_ready;
  assign push       = req_q & ~redirect;

  // Entries already committed to the FIFO after this cycle: queued plus the
  // one returning now, minus the one decode takes. A new issue lands one cycle
  // later, so it is allowed only while a slot remains for it.
  assign credits_used = {1'b0, count_q}
                      + {{CW{1'b0}}, req_q}
                      - {{CW{1'b0}}, pop};
  assign issue = ~rst & ~redirect & (credits_used < (CW+1)'(DEPTH));

  assign push_word = req_sel_q ? imem_dout : bios_dout;

  // Memory ports always follow the fetch PC; reads have no side effects.
  assign imem_addr  = fetch_pc_q[IMEM_AW+1:2];
  assign bios_addr  = fetch_pc_q[BIOS_AW+1:2];
  assign fetch_pc   = fetch_pc_q;
  assign fifo_count = count_q;
  assign inst       = inst_valid ? inst_mem[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : '0;

  // Next-state for fetch PC, in-flight request and FIFO pointers/count.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_d      = issue;
    req_pc_d   = req_pc_q;
    req_sel_d  = req_sel_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        req_pc_d   = fetch_pc_q;
        req_sel_d  = (fetch_pc_q[XLEN-1:XLEN-4] == IMEM_REGION);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State registers; reset overrides redirect and everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= XLEN'(RESET_PC);
      req_q      <= 1'b0;
      req_pc_q   <= '0;
      req_sel_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      req_pc_q   <= req_pc_d;
      req_sel_q  <= req_sel_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Write the returning word and its PC at the tail.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem[wr_ptr_q] <= push_word;
      pc_mem[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: reset, streaming, region steering, stall,
// redirect with work in flight, redirect+reset collision and PC wrap.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout;
  logic [11:0] bios_addr;
  logic [31:0] bios_dout;
  logic [31:0] fetch_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  if_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .bios_addr   (bios_addr),
    .bios_dout   (bios_dout),
    .fetch_pc    (fetch_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Synchronous memories: BIOS word k holds k, IMEM word k holds A000_0000+k.
  always @(posedge clk) begin
    bios_dout <= {20'h0, bios_addr};
    imem_dout <= 32'hA000_0000 | {18'h0, imem_addr};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // The credit rule must never let the queue exceed DEPTH.
  always @(negedge clk) begin
    if (fifo_count > 3'd4) chk("overflow", {29'h0, fifo_count}, 32'd4);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic do_reset(input logic ready);
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = ready;
    repeat (3) tick();
    chk("rst_valid", {31'h0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_count", {29'h0, fifo_count}, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    rst = 1'b0;
  endtask

  // Redirect in cycle n, then check the two empty cycles and the target head.
  task automatic do_redirect(input logic [31:0] tgt, input logic [31:0] exp_pc,
                             input logic [31:0] exp_inst);
    redirect = 1'b1; redirect_pc = tgt;
    tick();
    redirect = 1'b0;
    chk("redir_n1_valid", {31'h0, inst_valid}, 32'd0);
    chk("redir_n1_count", {29'h0, fifo_count}, 32'd0);
    chk("redir_n1_fetch_pc", fetch_pc, exp_pc);
    tick();
    chk("redir_n2_valid", {31'h0, inst_valid}, 32'd0);
    tick();
    chk("redir_n3_valid", {31'h0, inst_valid}, 32'd1);
    chk("redir_n3_pc", inst_pc, exp_pc);
    chk("redir_n3_inst", inst, exp_inst);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;

    // Reset release and streaming from BIOS.
    do_reset(1'b1);
    chk("c0_valid", {31'h0, inst_valid}, 32'd0);
    tick();
    chk("c1_valid", {31'h0, inst_valid}, 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("stream_valid", {31'h0, inst_valid}, 32'd1);
      chk("stream_pc", inst_pc, 32'(4 * k));
      chk("stream_inst", inst, 32'(k));
      chk("stream_count", {29'h0, fifo_count}, 32'd1);
      tick();
    end

    // Region steering into IMEM while streaming (pop in redirect cycle).
    do_redirect(32'h1000_0010, 32'h1000_0010, 32'hA000_0004);
    tick();
    chk("imem_next_pc", inst_pc, 32'h1000_0014);
    chk("imem_next_inst", inst, 32'hA000_0005);

    // Wrap from the top of the address space.
    do_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0FFF);
    tick();
    chk("wrap_pc", inst_pc, 32'h0000_0000);
    chk("wrap_inst", inst, 32'h0000_0000);
    tick();
    chk("wrap_pc2", inst_pc, 32'h0000_0004);

    // Stall from reset: queue fills to 4, fetch holds after issuing PC 12.
    do_reset(1'b0);
    repeat (4) tick();
    chk("stall_c4_count", {29'h0, fifo_count}, 32'd3);
    repeat (6) tick();
    chk("stall_count", {29'h0, fifo_count}, 32'd4);
    chk("stall_fetch_pc", fetch_pc, 32'd16);
    chk("stall_head_pc", inst_pc, 32'd0);
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("release_valid", {31'h0, inst_valid}, 32'd1);
      chk("release_pc", inst_pc, 32'(4 * k));
      chk("release_inst", inst, 32'(k));
      tick();
    end

    // Redirect with 3 queued and one request in flight; misaligned target.
    do_reset(1'b0);
    repeat (4) tick();
    chk("flight_count", {29'h0, fifo_count}, 32'd3);
    inst_ready = 1'b1;
    do_redirect(32'h0000_0103, 32'h0000_0100, 32'h0000_0040);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("after_redir_pc", inst_pc, 32'h0000_0100 + 32'(4 * k));
      chk("after_redir_inst", inst, 32'h0000_0040 + 32'(k));
    end

    // Redirect and reset together: reset wins.
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    rst = 1'b0; redirect = 1'b0;
    chk("collide_fetch_pc", fetch_pc, 32'h0);
    chk("collide_valid", {31'h0, inst_valid}, 32'd0);
    tick();
    tick();
    chk("collide_head_pc", inst_pc, 32'h0);
    chk("collide_head_inst", inst, 32'h0);
    tick();
    chk("collide_next_pc", inst_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
